dmem_responder: RTL and testbench

Memory-side responder for the core's load/store port. It accepts one request at a time from the pipeline's MEM stage over a valid/ready handshake. It inserts a configurable number of wait states and performs byte, halfword or word access into a word-organised local array, with sign or zero extension. The result is returned over a second valid/ready handshake. The block replaces the zero-latency data memory model, so stall logic can be exercised against a realistic multi-cycle memory.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 96 +++++++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the dmem_responder load/store memory.
// Funct3 encodings, responder state enum and wait-counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables/replicated data, load extension, legality.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic        illegal;
  logic        misalign;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    illegal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;
      default:          illegal = 1'b1;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    case (funct3)
      F3_H, F3_HU: misalign = addr_lo[0];
      F3_W:        misalign = |addr_lo;
      default:     misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
  end

  assign err = illegal | misalign;

  always_comb begin
    byte_sel = '0;
    case (addr_lo)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
  end

  // Halfword lane uses addr[1] only; addr[0] is either flagged or ignored.
  assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be        = '0;
    wdata_sh  = '0;
    rdata_ext = '0;
    if (!err) begin
      if (we) begin
        case (funct3)
          F3_B: begin
            be       = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[7:0]}};
          end
          F3_H: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
          end
          F3_W: begin
            be       = '1;
            wdata_sh = wdata;
          end
          default: begin
            be       = '0;
            wdata_sh = '0;
          end
        endcase
      end else begin
        case (funct3)
          F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
          F3_BU:   rdata_ext = {24'd0, byte_sel};
          F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
          F3_HU:   rdata_ext = {16'd0, half_sel};
          F3_W:    rdata_ext = rword;
          default: rdata_ext = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: valid/ready request, WAIT_CYCLES wait states, registered response.
// Optional misalignment checking is enabled with DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [31:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0]  widx;
  logic [31:0]        rword;
  logic [3:0]         be;
  logic [31:0]        wdata_sh;
  logic [31:0]        rdata_ext;
  logic               err;

  // Address bits above the array are intentionally ignored (aliasing).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign widx  = addr_q[ADDR_W+1:2];
  assign rword = mem[widx];

  dmem_lane_align u_lane_align (
    .we        (we_q),
    .funct3    (funct3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .err       (err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr[ADDR_W+1:0];
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          state_d  = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err;
        rsp_rdata_d = we_q ? '0 : rdata_ext;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && we_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, stall/reset sequences, randomized ops vs byte model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [2:0]  a_req_funct3;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [2:0]  b_req_funct3;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_funct3(a_req_funct3), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_funct3(b_req_funct3), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] mdl [0:4095];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] er_d, input logic ee);
    vec_t v;
    v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wd; v.exp_rdata = er_d; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_req(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wd);
    if (sel) begin
      b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_funct3 = f3; b_req_wdata = wd;
    end else begin
      a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_funct3 = f3; a_req_wdata = wd;
    end
  endtask

  function automatic logic rdy(input bit sel);         return sel ? b_req_ready : a_req_ready; endfunction
  function automatic logic rv(input bit sel);          return sel ? b_rsp_valid : a_rsp_valid; endfunction
  function automatic logic [31:0] rdat(input bit sel); return sel ? b_rsp_rdata : a_rsp_rdata; endfunction
  function automatic logic rerr(input bit sel);        return sel ? b_rsp_err : a_rsp_err; endfunction

  task automatic set_rsp_ready(input bit sel, input logic v);
    if (sel) b_rsp_ready = v; else a_rsp_ready = v;
  endtask

  // Called #1 after a rising edge; returns #1 after the response handshake edge.
  task automatic txn(input bit sel, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int n;
    drive_req(sel, 1'b1, we, addr, f3, wd);
    n = 0;
    while (!rdy(sel) && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    drive_req(sel, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    lat = 0;
    while (!rv(sel) && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = rdat(sel);
    er = rerr(sel);
    set_rsp_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(sel, 1'b0);
  endtask

  // Byte-level reference: memory is 4096 bytes, address taken modulo its size.
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned size, base;
    logic legal;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    base  = addr % 4096;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (base % size != 0) legal = 1'b0;
`else
    base = base - base % size;
`endif
    rd = 32'h0;
    er = !legal;
    if (!legal) return;
    if (we) begin
      for (int unsigned i = 0; i < size; i++) mdl[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int unsigned i = 0; i < size; i++) v = v | (32'(mdl[base + i]) << (8*i));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd, stall_word, word10;
    logic        er, eer;
    int          lat;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] wd;

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;

    #12;
    check("rst_req_ready", a_req_ready, 1);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_rdata", a_rsp_rdata, 0);
    check("rst_rsp_err",   a_rsp_err, 0);
    check("rst_busy",      a_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(mk(1, 32'h10,   F3_W,   32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,   F3_W,   32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 32'h13,   F3_B,   32'h0,        32'hFFFFFFDE, 0));
    vecs.push_back(mk(0, 32'h13,   F3_BU,  32'h0,        32'h000000DE, 0));
    vecs.push_back(mk(0, 32'h12,   F3_H,   32'h0,        32'hFFFFDEAD, 0));
    vecs.push_back(mk(0, 32'h10,   F3_HU,  32'h0,        32'h0000BEEF, 0));
    vecs.push_back(mk(1, 32'h11,   F3_B,   32'h00000055, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,   F3_W,   32'h0,        32'hDEAD55EF, 0));
    vecs.push_back(mk(0, 32'h10,   3'b011, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 32'h10,   3'b011, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk(1, 32'h10,   F3_BU,  32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk(0, 32'h12,   3'b110, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   F3_W,   32'h0,        32'hDEAD55EF, 0));
    vecs.push_back(mk(0, 32'h1010, F3_W,   32'h0,        32'hDEAD55EF, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 32'h12,   F3_W,   32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 32'h11,   F3_W,   32'hAAAAAAAA, 32'h0,        1));
    vecs.push_back(mk(0, 32'h11,   F3_H,   32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 32'h13,   F3_H,   32'h0000CAFE, 32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   F3_W,   32'h0,        32'hDEAD55EF, 0));
    word10 = 32'hDEAD55EF;
`else
    vecs.push_back(mk(0, 32'h12,   F3_W,   32'h0,        32'hDEAD55EF, 0));
    vecs.push_back(mk(0, 32'h11,   F3_H,   32'h0,        32'h000055EF, 0));
    vecs.push_back(mk(1, 32'h13,   F3_H,   32'h0000CAFE, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,   F3_W,   32'h0,        32'hCAFE55EF, 0));
    word10 = 32'hCAFE55EF;
`endif

    foreach (vecs[i]) begin
      txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i), lat, 3);
    end

    // Response back-pressure with a second request pending.
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, F3_W, 32'h0);
    @(posedge clk); #1;
    lat = 0;
    while (!a_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("stall_lat", lat, 3);
    stall_word = a_rsp_rdata;
    check("stall_rdata", stall_word, word10);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_valid", k), a_rsp_valid, 1);
      check($sformatf("stall%0d_rdata", k), a_rsp_rdata, stall_word);
      check($sformatf("stall%0d_req_ready", k), a_req_ready, 0);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check("stall_post_valid", a_rsp_valid, 0);
    check("stall_post_req_ready", a_req_ready, 1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    check("stall_accept_busy", a_busy, 1);
    check("stall_accept_req_ready", a_req_ready, 0);
    lat = 0;
    while (!a_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("stall2_lat", lat, 3);
    check("stall2_rdata", a_rsp_rdata, word10);
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;

    // Reset during WAIT of a store must drop the store.
    txn(1'b0, 1'b1, 32'h20, F3_W, 32'h11111111, rd, er, lat);
    check("rstw_init_err", er, 0);
    drive_req(1'b0, 1'b1, 1'b1, 32'h20, F3_W, 32'h22222222);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_rsp_valid", a_rsp_valid, 0);
    check("rstw_req_ready", a_req_ready, 1);
    check("rstw_busy", a_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("rstw_quiet%0d", k), a_rsp_valid, 0);
    end
    txn(1'b0, 1'b0, 32'h20, F3_W, 32'h0, rd, er, lat);
    check("rstw_load", rd, 32'h11111111);

    // Zero wait-state instance.
    txn(1'b1, 1'b1, 32'h10, F3_W, 32'h0BADF00D, rd, er, lat);
    check("w0_sw_lat", lat, 1);
    txn(1'b1, 1'b0, 32'h1010, F3_W, 32'h0, rd, er, lat);
    check("w0_lw_alias", rd, 32'h0BADF00D);
    check("w0_lw_lat", lat, 1);
    txn(1'b1, 1'b0, 32'h12, F3_B, 32'h0, rd, er, lat);
    check("w0_lb", rd, 32'hFFFFFFAD);

    // Randomized ops against the byte model in bytes 0x400..0x4FF with random alias bits.
    for (int unsigned w = 0; w < 64; w++) begin
      wd = $urandom();
      model(1'b1, 32'h400 + 4*w, F3_W, wd, erd, eer);
      txn(1'b0, 1'b1, 32'h400 + 4*w, F3_W, wd, rd, er, lat);
    end
    for (int i = 0; i < 150; i++) begin
      addr = ($urandom() & 32'hFFFF_F000) | (32'h400 + $urandom_range(0, 255));
      f3   = 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom();
      model(we, addr, f3, wd, erd, eer);
      txn(1'b0, we, addr, f3, wd, rd, er, lat);
      check($sformatf("rnd%0d_rdata(we=%0d a=%h f3=%0d)", i, we, addr, f3), rd, erd);
      check($sformatf("rnd%0d_err", i), er, eer);
      check($sformatf("rnd%0d_lat", i), lat, 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
